rpn_pop_exec: RTL and testbench
===============================

# rpn_pop_exec

Operator-execution side of the RPN calculator stack: pops the top two entries from the stack RAM, applies the selected operator, writes the result back as the new top, and requests a stack-pointer decrement. Sits beside the push path, which loads operands entered on the switches; both share the stack RAM and the stack pointer register, and the top level arbitrates so that a push and a pop are never active in the same cycle.

## Interface
- WIDTH, 8: data word width.
- AW, 8: stack RAM address width; stack pointer width.

- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- op_req  in  1  one-cycle request to execute an operator.
- op_sel  in  2  operator: 00 ADD, 01 SUB, 10 MUL, 11 AND.
- sp  in  AW  current stack depth; entries occupy addresses 0..sp-1, top at sp-1.
- ram_addr  out  AW  stack RAM address.
- ram_rdata  in  WIDTH  RAM read data, valid one cycle after ram_addr.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  WIDTH  RAM write data.
- sp_load  out  1  one-cycle strobe: load sp_next into the stack pointer.
- sp_next  out  AW  new stack depth.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  last computed result, held.
- err_underflow  out  1  sticky underflow flag.
- ovf  out  1  overflow flag of the last operation.

## Operation
- States: S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WRITE.
- S_IDLE: op_req=1 and sp>=2: latch op_sel and sp, clear err_underflow, go to S_RD_A. op_req=1 and sp<2: set err_underflow, stay in S_IDLE, no RAM access, no sp_load. op_req=0: stay.
- S_RD_A: ram_addr=sp-1, go to S_RD_B.
- S_RD_B: ram_addr=sp-2; capture ram_rdata into A (top). Go to S_EXEC.
- S_EXEC: capture ram_rdata into B (second). Go to S_WRITE.
- S_WRITE: ram_we=1, ram_addr=sp-2, ram_wdata=f(B,A); result<=f(B,A); sp_load=1, sp_next=sp-1; done=1. Go to S_IDLE.
- Arithmetic is WIDTH bits, modulo 2^WIDTH: ADD B+A; SUB B-A (second minus top); MUL low WIDTH bits of B*A; AND B&A.
- op_req while busy is ignored, not queued.
- The latched sp is used for all addressing; changes on sp during an operation have no effect.

## Timing
- op_req sampled at edge 0: busy high cycles 1-4; done, ram_we, sp_load high in cycle 4 only; next request accepted in cycle 5. Latency request-to-done: 4 cycles.
- err_underflow asserts the cycle after the rejected request; it remains set until the next accepted request or reset.
- Reset values: state S_IDLE; busy, done, ram_we, sp_load, err_underflow, ovf = 0; ram_addr, ram_wdata, sp_next, result = 0.
- Reset mid-operation: return to S_IDLE next edge, no RAM write, no sp_load, latched operands discarded.
- ram_we, sp_load, done: single-cycle pulses, never held.

## Configuration
- RPN_OVERFLOW_FLAG_EN defined: ovf is updated in S_WRITE. Set on ADD carry-out, SUB borrow (A>B unsigned), or MUL nonzero upper WIDTH bits; AND always 0. ovf holds until the next S_WRITE or reset.
- Not defined: ovf is tied to 0 and no carry/high-product logic is built.

## Structure
- Shared package/header rpn_defs: operator codes (`OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_AND`) and state encodings, shared with the push path.
- Sub-module rpn_alu: combinational, inputs B, A, op; outputs result and overflow.

## Test plan
- sp=2, mem[0]=7, mem[1]=5, op ADD -> cycle 4: ram_we=1, addr 0, wdata 12; sp_load=1, sp_next=1; done=1; result=12.
- sp=3, mem[1]=3, mem[2]=5, op SUB -> wdata 8'hFE at addr 1; sp_next=2; with RPN_OVERFLOW_FLAG_EN, ovf=1.
- sp=2, mem[0]=8'h20, mem[1]=8'h10, op MUL -> wdata 8'h00, ovf=1 (macro on) or 0 (macro off).
- sp=1, op_req -> err_underflow=1 next cycle; busy, ram_we, sp_load stay 0. A later valid ADD clears the flag.
- op_req pulsed again in cycles 1-3 of an operation -> ignored; exactly one done pulse, one sp_load.
- reset_n low in S_EXEC -> next cycle all outputs at reset values; no ram_we or sp_load ever asserted for that operation.

Source files
------------

// File: rtl/rpn_defs_pkg.sv
// Shared RPN calculator definitions: word/address widths, operator codes and
// controller state encodings, used by both the push and the pop/execute paths.
package rpn_defs_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4
  } state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational operator unit: y = f(b, a) where b is the second entry, a the top.
// With RPN_OVERFLOW_FLAG_EN defined, carry/borrow/high-product detection is built.
module rpn_alu
  import rpn_defs_pkg::*;
(
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

`ifdef RPN_OVERFLOW_FLAG_EN
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  assign sum  = {1'b0, b} + {1'b0, a};
  assign prod = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, a};

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        y   = sum[WIDTH-1:0];
        ovf = sum[WIDTH];
      end
      OP_SUB: begin
        y   = b - a;
        ovf = (a > b);
      end
      OP_MUL: begin
        y   = prod[WIDTH-1:0];
        ovf = |prod[2*WIDTH-1:WIDTH];
      end
      OP_AND: y = b & a;
      default: y = '0;
    endcase
  end
`else
  assign ovf = 1'b0;

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = b + a;
      OP_SUB:  y = b - a;
      OP_MUL:  y = b * a;
      OP_AND:  y = b & a;
      default: y = '0;
    endcase
  end
`endif

endmodule

// File: rtl/rpn_pop_exec.sv
// Pop/execute controller: reads top two stack entries, applies the operator,
// writes the result as new top and strobes a stack-pointer decrement.
// Optional feature macro: RPN_OVERFLOW_FLAG_EN (registered ovf output).
module rpn_pop_exec
  import rpn_defs_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             op_req,
  input  logic [1:0]       op_sel,
  input  logic [AW-1:0]    sp,
  output logic [AW-1:0]    ram_addr,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             sp_load,
  output logic [AW-1:0]    sp_next,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err_underflow,
  output logic             ovf
);

  state_e           state, state_d;
  logic [AW-1:0]    sp_lat, sp_lat_d;
  op_e              op_lat, op_lat_d;
  logic [WIDTH-1:0] opa, opa_d;
  logic [AW-1:0]    ram_addr_d, sp_next_d;
  logic [WIDTH-1:0] ram_wdata_d, result_d;
  logic             ram_we_d, sp_load_d, busy_d, done_d, err_d;
  logic [WIDTH-1:0] alu_y;
  logic             alu_ovf;

  // Second operand is consumed straight off the RAM read port in S_EXEC.
  rpn_alu u_alu (
    .b   (ram_rdata),
    .a   (opa),
    .op  (op_lat),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

`ifdef RPN_OVERFLOW_FLAG_EN
  logic ovf_d;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      sp_lat        <= '0;
      op_lat        <= OP_ADD;
      opa           <= '0;
      ram_addr      <= '0;
      ram_we        <= 1'b0;
      ram_wdata     <= '0;
      sp_load       <= 1'b0;
      sp_next       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      err_underflow <= 1'b0;
`ifdef RPN_OVERFLOW_FLAG_EN
      ovf           <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      sp_lat        <= sp_lat_d;
      op_lat        <= op_lat_d;
      opa           <= opa_d;
      ram_addr      <= ram_addr_d;
      ram_we        <= ram_we_d;
      ram_wdata     <= ram_wdata_d;
      sp_load       <= sp_load_d;
      sp_next       <= sp_next_d;
      busy          <= busy_d;
      done          <= done_d;
      result        <= result_d;
      err_underflow <= err_d;
`ifdef RPN_OVERFLOW_FLAG_EN
      ovf           <= ovf_d;
`endif
    end
  end

`ifndef RPN_OVERFLOW_FLAG_EN
  assign ovf = alu_ovf;
`endif

  // Next-state and next-output values; outputs land one edge later.
  always_comb begin
    state_d     = state;
    sp_lat_d    = sp_lat;
    op_lat_d    = op_lat;
    opa_d       = opa;
    ram_addr_d  = ram_addr;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata;
    sp_load_d   = 1'b0;
    sp_next_d   = sp_next;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    result_d    = result;
    err_d       = err_underflow;
`ifdef RPN_OVERFLOW_FLAG_EN
    ovf_d       = ovf;
`endif
    case (state)
      S_IDLE: begin
        if (op_req) begin
          if (sp >= AW'(2)) begin
            state_d    = S_RD_A;
            sp_lat_d   = sp;
            op_lat_d   = op_e'(op_sel);
            err_d      = 1'b0;
            ram_addr_d = sp - AW'(1);
            busy_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RD_A: begin
        state_d    = S_RD_B;
        ram_addr_d = sp_lat - AW'(2);
        busy_d     = 1'b1;
      end
      S_RD_B: begin
        state_d = S_EXEC;
        opa_d   = ram_rdata;
        busy_d  = 1'b1;
      end
      S_EXEC: begin
        state_d     = S_WRITE;
        busy_d      = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = sp_lat - AW'(2);
        ram_wdata_d = alu_y;
        result_d    = alu_y;
        sp_load_d   = 1'b1;
        sp_next_d   = sp_lat - AW'(1);
        done_d      = 1'b1;
`ifdef RPN_OVERFLOW_FLAG_EN
        ovf_d       = alu_ovf;
`endif
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rpn_pop_exec.sv
// Directed self-checking bench for rpn_pop_exec with a synchronous stack RAM model.
// Expected ovf values follow RPN_OVERFLOW_FLAG_EN.
module tb_rpn_pop_exec;
  import rpn_defs_pkg::*;

`ifdef RPN_OVERFLOW_FLAG_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic             CLOCK_50 = 1'b0;
  logic             reset_n  = 1'b0;
  logic             op_req   = 1'b0;
  logic [1:0]       op_sel   = 2'b00;
  logic [AW-1:0]    sp       = '0;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_rdata = '0;
  logic             ram_we;
  logic [WIDTH-1:0] ram_wdata;
  logic             sp_load;
  logic [AW-1:0]    sp_next;
  logic             busy, done, err_underflow, ovf;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] mem [256];
  int n_vec = 0;
  int n_err = 0;

  rpn_pop_exec dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .op_req        (op_req),
    .op_sel        (op_sel),
    .sp            (sp),
    .ram_addr      (ram_addr),
    .ram_rdata     (ram_rdata),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .sp_load       (sp_load),
    .sp_next       (sp_next),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .err_underflow (err_underflow),
    .ovf           (ovf)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_we"},    32'(ram_we), 0);
    check({tag, "_load"},  32'(sp_load), 0);
    check({tag, "_err"},   32'(err_underflow), 0);
    check({tag, "_ovf"},   32'(ovf), 0);
    check({tag, "_addr"},  32'(ram_addr), 0);
    check({tag, "_wdata"}, 32'(ram_wdata), 0);
    check({tag, "_spn"},   32'(sp_next), 0);
    check({tag, "_res"},   32'(result), 0);
  endtask

  // Issue one operator; disturb re-asserts op_req and scrambles sp during cycles 1-3.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [AW-1:0] depth,
                        input logic [WIDTH-1:0] exp_y, input logic exp_ovf_raw, input bit disturb);
    int dones = 0;
    int loads = 0;
    int wes   = 0;
    logic exp_ovf;
    exp_ovf = exp_ovf_raw & OVF_ON;
    @(negedge CLOCK_50);
    sp = depth; op_sel = op; op_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLOCK_50);
      op_req = disturb && (c <= 3);
      if (disturb && c <= 3) begin
        sp = AW'(c);
        op_sel = 2'b11 - op;
      end
      dones += int'(done);
      loads += int'(sp_load);
      wes   += int'(ram_we);
      if (c == 1) begin
        check({tag, "_busy1"}, 32'(busy), 1);
        check({tag, "_err1"},  32'(err_underflow), 0);
      end
      if (c == 4) begin
        check({tag, "_we"},    32'(ram_we), 1);
        check({tag, "_addr"},  32'(ram_addr), 32'(depth - AW'(2)));
        check({tag, "_wdata"}, 32'(ram_wdata), 32'(exp_y));
        check({tag, "_load"},  32'(sp_load), 1);
        check({tag, "_spn"},   32'(sp_next), 32'(depth - AW'(1)));
        check({tag, "_done"},  32'(done), 1);
        check({tag, "_res"},   32'(result), 32'(exp_y));
        check({tag, "_ovf"},   32'(ovf), 32'(exp_ovf));
        check({tag, "_busy4"}, 32'(busy), 1);
      end
      if (c == 5) begin
        check({tag, "_busy5"}, 32'(busy), 0);
        check({tag, "_mem"},   32'(mem[int'(depth) - 2]), 32'(exp_y));
        check({tag, "_hold"},  32'(result), 32'(exp_y));
        check({tag, "_ovfh"},  32'(ovf), 32'(exp_ovf));
      end
    end
    check({tag, "_ndone"}, 32'(dones), 1);
    check({tag, "_nload"}, 32'(loads), 1);
    check({tag, "_nwe"},   32'(wes), 1);
  endtask

  task automatic underflow(input string tag, input logic [AW-1:0] depth);
    @(negedge CLOCK_50);
    sp = depth; op_sel = 2'b00; op_req = 1'b1;
    @(negedge CLOCK_50);
    op_req = 1'b0;
    check({tag, "_err"},  32'(err_underflow), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_we"},   32'(ram_we), 0);
    check({tag, "_load"}, 32'(sp_load), 0);
    @(negedge CLOCK_50);
    check({tag, "_sticky"}, 32'(err_underflow), 1);
    check({tag, "_idle"},   32'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge CLOCK_50);
    check_reset_vals("rst");
    reset_n = 1'b1;

    mem[0] = 8'd7;    mem[1] = 8'd5;
    run_op("add", 2'b00, 8'd2, 8'd12, 1'b0, 1'b0);
    mem[1] = 8'd3;    mem[2] = 8'd5;
    run_op("sub", 2'b01, 8'd3, 8'hFE, 1'b1, 1'b0);
    mem[0] = 8'h20;   mem[1] = 8'h10;
    run_op("mul", 2'b10, 8'd2, 8'h00, 1'b1, 1'b0);
    mem[2] = 8'hF0;   mem[3] = 8'h3C;
    run_op("and", 2'b11, 8'd4, 8'h30, 1'b0, 1'b0);
    mem[0] = 8'hFF;   mem[1] = 8'h02;
    run_op("addc", 2'b00, 8'd2, 8'h01, 1'b1, 1'b0);

    underflow("uf1", 8'd1);
    underflow("uf0", 8'd0);
    mem[3] = 8'h40;   mem[4] = 8'h02;
    run_op("clr", 2'b00, 8'd5, 8'h42, 1'b0, 1'b0);

    mem[1] = 8'd3;    mem[2] = 8'd5;
    run_op("dist", 2'b10, 8'd3, 8'd15, 1'b0, 1'b1);

    // Reset asserted while the controller sits in S_EXEC.
    begin
      int wes = 0;
      int loads = 0;
      mem[0] = 8'h11; mem[1] = 8'h22;
      @(negedge CLOCK_50);
      sp = 8'd2; op_sel = 2'b00; op_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
        @(negedge CLOCK_50);
        op_req = 1'b0;
        wes   += int'(ram_we);
        loads += int'(sp_load);
        if (c == 3) begin
          check("rx_busy3", 32'(busy), 1);
          reset_n = 1'b0;
        end
        if (c == 4) begin
          check_reset_vals("rx");
          reset_n = 1'b1;
        end
      end
      check("rx_nwe",   32'(wes), 0);
      check("rx_nload", 32'(loads), 0);
      check("rx_mem",   32'(mem[0]), 32'h11);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
